// File: rtl/pong_pkg.sv
// Shared Pong display constants: screen geometry, RGB565 colours, renderer FSM states.
// Coordinate widths are fixed by the column/row address buses (X 8 bits, Y 9 bits).
package pong_pkg;

  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 320;

  localparam int X_W     = 8;
  localparam int Y_W     = 9;
  localparam int BOUND_W = 10;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SCAN,
    DONE
  } render_state_t;

endpackage

// File: rtl/pong_rect_hit.sv
// Combinational point-in-rectangle test; bounds are 10 bits wide so rectangles near
// the screen edge are clipped instead of wrapping round to column/row 0.
module pong_rect_hit
  import pong_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] left,
  input  logic [Y_W-1:0] top,
  output logic           hit
);

  logic [BOUND_W-1:0] x_ext, y_ext, x_lo, x_hi, y_lo, y_hi;

  always_comb begin
    x_ext = BOUND_W'(x);
    y_ext = BOUND_W'(y);
    x_lo  = BOUND_W'(left);
    y_lo  = BOUND_W'(top);
    x_hi  = x_lo + BOUND_W'(WIDTH - 1);
    y_hi  = y_lo + BOUND_W'(HEIGHT - 1);
    hit   = (x_ext >= x_lo) && (x_ext <= x_hi) && (y_ext >= y_lo) && (y_ext <= y_hi);
  end

endmodule

// File: rtl/pong_frame_renderer.sv
// Raster renderer: one frame per frame_start, first pixel valid 2 cycles after the request.
// A low pixel_ready holds x/y/pixel_data stable and withholds x_enable from the column counter.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int          X_MAX      = SCREEN_W - 1,
  parameter int          Y_MAX      = SCREEN_H - 1,
  parameter int          BALL_SIZE  = 8,
  parameter int          PADDLE_W   = 6,
  parameter int          PADDLE_H   = 40,
  parameter int          PADDLE_L_X = 8,
  parameter int          PADDLE_R_X = 226,
  parameter logic [15:0] FG_COLOUR  = RGB565_WHITE,
  parameter logic [15:0] BG_COLOUR  = RGB565_BLACK
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_start,
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] paddle_l_y,
  input  logic [Y_W-1:0] paddle_r_y,
  input  logic [X_W-1:0] x_addr,
  output logic           x_enable,
  output logic [Y_W-1:0] y_addr,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  input  logic           pixel_ready,
  output logic           busy,
  output logic           frame_done
);

  render_state_t  state, state_nxt;
  logic [X_W-1:0] ball_x_q;
  logic [Y_W-1:0] ball_y_q, paddle_l_y_q, paddle_r_y_q;
  logic           handshake, last_col, last_row;
  logic           hit_ball, hit_left, hit_right;

  assign handshake = (state == SCAN) && pixel_ready;
  assign last_col  = (x_addr == X_W'(X_MAX));
  assign last_row  = (y_addr == Y_W'(Y_MAX));

  pong_rect_hit #(.WIDTH(BALL_SIZE), .HEIGHT(BALL_SIZE)) u_ball (
    .x(x_addr), .y(y_addr), .left(ball_x_q), .top(ball_y_q), .hit(hit_ball)
  );

  pong_rect_hit #(.WIDTH(PADDLE_W), .HEIGHT(PADDLE_H)) u_paddle_l (
    .x(x_addr), .y(y_addr), .left(X_W'(PADDLE_L_X)), .top(paddle_l_y_q), .hit(hit_left)
  );

  pong_rect_hit #(.WIDTH(PADDLE_W), .HEIGHT(PADDLE_H)) u_paddle_r (
    .x(x_addr), .y(y_addr), .left(X_W'(PADDLE_R_X)), .top(paddle_r_y_q), .hit(hit_right)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      y_addr       <= '0;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      paddle_l_y_q <= '0;
      paddle_r_y_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == LATCH) begin
        ball_x_q     <= ball_x;
        ball_y_q     <= ball_y;
        paddle_l_y_q <= paddle_l_y;
        paddle_r_y_q <= paddle_r_y;
        y_addr       <= '0;
      end else if (handshake && last_col && !last_row) begin
        y_addr <= y_addr + 1'b1;
      end
    end
  end

  // Outside SCAN the pixel bus idles at background so stale positions never leak out.
  always_comb begin
    state_nxt   = state;
    x_enable    = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = BG_COLOUR;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = LATCH;
      end
      LATCH: state_nxt = SCAN;
      SCAN: begin
        pixel_valid = 1'b1;
        x_enable    = pixel_ready;
        pixel_data  = (hit_ball || hit_left || hit_right) ? FG_COLOUR : BG_COLOUR;
        if (handshake && last_col && last_row) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Bench for pong_frame_renderer on a full-width, 24-row screen with a behavioural column counter
// and a rectangle-membership reference for every pixel.
module tb_pong_frame_renderer;

  localparam int XM   = 239;
  localparam int YM   = 23;
  localparam int BS   = 8;
  localparam int PW   = 6;
  localparam int PH   = 8;
  localparam int PLX  = 8;
  localparam int PRX  = 226;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;
  localparam int NPIX = (XM + 1) * (YM + 1);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_ready = 1'b0;
  logic [7:0]  ball_x = '0;
  logic [8:0]  ball_y = '0, paddle_l_y = '0, paddle_r_y = '0;
  logic [7:0]  x_addr;
  logic        x_enable, pixel_valid, busy, frame_done;
  logic [8:0]  y_addr;
  logic [15:0] pixel_data;

  int checks = 0;
  int errors = 0;

  pong_frame_renderer #(
    .X_MAX(XM), .Y_MAX(YM), .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
    .PADDLE_L_X(PLX), .PADDLE_R_X(PRX), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .x_addr(x_addr), .x_enable(x_enable), .y_addr(y_addr),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Neighbouring column counter: steps on x_enable, wraps after the last column.
  always @(posedge clock or posedge reset) begin
    if (reset) x_addr <= 8'd0;
    else if (x_enable) x_addr <= (x_addr == 8'(XM)) ? 8'd0 : x_addr + 8'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rect(int x, int y, int l, int t, int w, int h);
    return (x >= l) && (x < l + w) && (y >= t) && (y < t + h);
  endfunction

  function automatic logic [15:0] ref_pixel(int x, int y, int bx, int by, int pl, int pr);
    bit hit;
    hit = in_rect(x, y, bx, by, BS, BS) || in_rect(x, y, PLX, pl, PW, PH) ||
          in_rect(x, y, PRX, pr, PW, PH);
    return hit ? FG : BG;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(pixel_valid), 32'd0);
    check_val({tag, "_xen"},   32'(x_enable),    32'd0);
    check_val({tag, "_busy"},  32'(busy),        32'd0);
    check_val({tag, "_done"},  32'(frame_done),  32'd0);
    check_val({tag, "_yaddr"}, 32'(y_addr),      32'd0);
    check_val({tag, "_data"},  32'(pixel_data),  32'(BG));
  endtask

  // chg_row >= 0 disturbs the position inputs mid-frame; abort_row >= 0 resets at that pixel;
  // poke_done raises frame_start during the DONE cycle.
  task automatic run_frame(input int bx, input int by, input int pl, input int pr,
                           input int stall_pct, input int chg_row,
                           input int abort_col, input int abort_row, input bit poke_done);
    int ex, ey, nhs, k;
    bit held, fin, aborted;
    logic [15:0] held_dat;
    @(negedge clock);
    ball_x = 8'(bx); ball_y = 9'(by); paddle_l_y = 9'(pl); paddle_r_y = 9'(pr);
    pixel_ready = 1'b0;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    #1;
    check_val("latch_busy",  32'(busy),        32'd1);
    check_val("latch_valid", 32'(pixel_valid), 32'd0);
    ex = 0; ey = 0; nhs = 0; k = 1; held = 0; fin = 0; aborted = 0; held_dat = '0;
    while (!fin) begin
      @(negedge clock);
      k++;
      pixel_ready = (int'($urandom_range(99)) >= stall_pct);
      if (chg_row >= 0 && ey >= chg_row) begin
        paddle_l_y = 9'(pl + 180);
        ball_x     = 8'(bx + 37);
        ball_y     = 9'(by + 7);
      end
      #1;
      if (frame_done) begin
        check_val("done_handshakes", 32'(nhs), 32'(NPIX));
        if (stall_pct == 0) check_val("frame_len", 32'(k), 32'(NPIX + 2));
        if (poke_done) frame_start = 1'b1;
        fin = 1;
      end else if (k > 4 * NPIX + 100) begin
        check_val("frame_timeout", 32'(k), 32'(NPIX + 2));
        fin = 1;
      end else begin
        check_val("valid", 32'(pixel_valid), 32'd1);
        check_val("x_addr", 32'(x_addr), 32'(ex));
        check_val("y_addr", 32'(y_addr), 32'(ey));
        check_val("pixel", 32'(pixel_data), 32'(ref_pixel(ex, ey, bx, by, pl, pr)));
        check_val("x_enable", 32'(x_enable), 32'(pixel_ready));
        if (held) check_val("stall_hold", 32'(pixel_data), 32'(held_dat));
        held     = !pixel_ready;
        held_dat = pixel_data;
        if (ex == abort_col && ey == abort_row) begin
          reset = 1'b1;
          #1;
          check_idle_outputs("abort");
          @(negedge clock);
          reset = 1'b0;
          fin = 1;
          aborted = 1;
        end else if (pixel_ready) begin
          nhs++;
          if (ex == XM) begin
            ex = 0;
            ey++;
          end else begin
            ex++;
          end
        end
      end
    end
    pixel_ready = 1'b0;
    if (!aborted) begin
      @(negedge clock);
      frame_start = 1'b0;
      #1;
      check_val("post_done",  32'(frame_done),  32'd0);
      check_val("post_busy",  32'(busy),        32'd0);
      check_val("post_valid", 32'(pixel_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_idle_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check_idle_outputs("idle");

    run_frame(100, 10, 3, 14, 0, -1, -1, -1, 1'b0);
    run_frame(236, 20, 0, 16, 30, -1, -1, -1, 1'b1);
    run_frame(int'($urandom_range(255)), int'($urandom_range(31)),
              int'($urandom_range(31)), int'($urandom_range(31)), 40, -1, -1, -1, 1'b0);
    run_frame(60, 5, 2, 9, 20, 4, -1, -1, 1'b0);
    run_frame(50, 8, 8, 8, 25, -1, 50, 10, 1'b0);
    run_frame(int'($urandom_range(255)), int'($urandom_range(31)),
              int'($urandom_range(31)), int'($urandom_range(31)), 10, -1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
